// File: rtl/skewed_input_ctrl.sv
// skewed_input_ctrl: per-channel input FIFOs for a systolic array edge.
// A write pushes a full vector into every row and column FIFO as one all-or-nothing
// decision. A read starts a pop wave that reaches channel k k cycles after channel 0.
// Cycles with no pop on a channel output a zero word with valid low.
//
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   flush               synchronous soft clear (same effect as rst)
//   ainport / winport   activation (ROWS x DW) / weight (COLS x DW) input vectors
//   write / read        push a vector / start a skewed pop wave
//   afulls / wfulls     per-channel full flags
//   aemptys / wemptys   per-channel empty flags
//   as / ws             registered per-channel output words
//   avalid / wvalid     per-channel output valid
//   busy                a pop wave is still in flight past channel 0
//   err_ovf / err_udf   sticky overflow / underflow flags
module skewed_input_ctrl #(
    parameter int unsigned ROWS  = 8,
    parameter int unsigned COLS  = 8,
    parameter int unsigned DW    = 8,
    parameter int unsigned DEPTH = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 flush,
    input  logic [ROWS*DW-1:0]   ainport,
    input  logic [COLS*DW-1:0]   winport,
    input  logic                 write,
    input  logic                 read,
    output logic [ROWS-1:0]      afulls,
    output logic [COLS-1:0]      wfulls,
    output logic [ROWS-1:0]      aemptys,
    output logic [COLS-1:0]      wemptys,
    output logic [ROWS*DW-1:0]   as,
    output logic [COLS*DW-1:0]   ws,
    output logic [ROWS-1:0]      avalid,
    output logic [COLS-1:0]      wvalid,
    output logic                 busy,
    output logic                 err_ovf,
    output logic                 err_udf
);

    localparam int unsigned AW    = $clog2(DEPTH);
    localparam int unsigned CW    = AW + 1;
    localparam int unsigned MAXRC = (ROWS > COLS) ? ROWS : COLS;
    // Delay line holds read delayed by 1..MAXRC-1 cycles; kept at least one bit wide.
    localparam int unsigned DLYW  = (MAXRC > 1) ? MAXRC - 1 : 1;

    // FIFO storage (not reset; contents are only meaningful under the counts)
    logic [DW-1:0] amem_q [ROWS][DEPTH];
    logic [DW-1:0] wmem_q [COLS][DEPTH];

    logic [AW-1:0] a_wp_q [ROWS], a_wp_d [ROWS];
    logic [AW-1:0] a_rp_q [ROWS], a_rp_d [ROWS];
    logic [CW-1:0] a_cnt_q[ROWS], a_cnt_d[ROWS];
    logic [AW-1:0] w_wp_q [COLS], w_wp_d [COLS];
    logic [AW-1:0] w_rp_q [COLS], w_rp_d [COLS];
    logic [CW-1:0] w_cnt_q[COLS], w_cnt_d[COLS];

    logic [ROWS*DW-1:0] as_q, as_d;
    logic [COLS*DW-1:0] ws_q, ws_d;
    logic [ROWS-1:0]    avalid_q, avalid_d;
    logic [COLS-1:0]    wvalid_q, wvalid_d;
    logic [DLYW-1:0]    dly_q, dly_d;
    logic               err_ovf_q, err_ovf_d;
    logic               err_udf_q, err_udf_d;

    logic [MAXRC-1:0]   pop_c;
    logic               wr_acc_c;

    // Per-channel status straight from the counts
    always_comb begin : status
        for (int unsigned i = 0; i < ROWS; i++) begin
            afulls[i]  = (a_cnt_q[i] == CW'(DEPTH));
            aemptys[i] = (a_cnt_q[i] == '0);
        end
        for (int unsigned j = 0; j < COLS; j++) begin
            wfulls[j]  = (w_cnt_q[j] == CW'(DEPTH));
            wemptys[j] = (w_cnt_q[j] == '0);
        end
    end

    // Channel k pops when read was high k cycles ago; channel 0 uses read directly
    always_comb begin : pop_select
        pop_c    = '0;
        pop_c[0] = read;
        for (int unsigned k = 1; k < MAXRC; k++) begin
            pop_c[k] = dly_q[k-1];
        end
        // Whole-vector write decision uses pre-pop fullness
        wr_acc_c = write && !((|afulls) || (|wfulls));
    end

    always_comb begin : next_state
        logic pop_ok;
        logic udf;
        pop_ok    = 1'b0;
        udf       = 1'b0;
        dly_d     = DLYW'({dly_q, read});
        as_d      = '0;
        ws_d      = '0;
        avalid_d  = '0;
        wvalid_d  = '0;
        a_wp_d    = a_wp_q;
        a_rp_d    = a_rp_q;
        a_cnt_d   = a_cnt_q;
        w_wp_d    = w_wp_q;
        w_rp_d    = w_rp_q;
        w_cnt_d   = w_cnt_q;
        err_ovf_d = err_ovf_q | (write & ~wr_acc_c);

        for (int unsigned i = 0; i < ROWS; i++) begin
            pop_ok = pop_c[i] && (a_cnt_q[i] != '0);
            if (pop_c[i] && !pop_ok) udf = 1'b1;
            if (pop_ok) begin
                as_d[i*DW +: DW] = amem_q[i][a_rp_q[i]];
                avalid_d[i]      = 1'b1;
                a_rp_d[i]        = a_rp_q[i] + AW'(1);
            end
            if (wr_acc_c) a_wp_d[i] = a_wp_q[i] + AW'(1);
            a_cnt_d[i] = a_cnt_q[i] + CW'(wr_acc_c) - CW'(pop_ok);
        end

        for (int unsigned j = 0; j < COLS; j++) begin
            pop_ok = pop_c[j] && (w_cnt_q[j] != '0);
            if (pop_c[j] && !pop_ok) udf = 1'b1;
            if (pop_ok) begin
                ws_d[j*DW +: DW] = wmem_q[j][w_rp_q[j]];
                wvalid_d[j]      = 1'b1;
                w_rp_d[j]        = w_rp_q[j] + AW'(1);
            end
            if (wr_acc_c) w_wp_d[j] = w_wp_q[j] + AW'(1);
            w_cnt_d[j] = w_cnt_q[j] + CW'(wr_acc_c) - CW'(pop_ok);
        end

        err_udf_d = err_udf_q | udf;

        // Soft clear overrides everything except reset
        if (flush) begin
            dly_d     = '0;
            as_d      = '0;
            ws_d      = '0;
            avalid_d  = '0;
            wvalid_d  = '0;
            err_ovf_d = 1'b0;
            err_udf_d = 1'b0;
            for (int unsigned i = 0; i < ROWS; i++) begin
                a_wp_d[i]  = '0;
                a_rp_d[i]  = '0;
                a_cnt_d[i] = '0;
            end
            for (int unsigned j = 0; j < COLS; j++) begin
                w_wp_d[j]  = '0;
                w_rp_d[j]  = '0;
                w_cnt_d[j] = '0;
            end
        end
    end

    // FIFO storage write
    always_ff @(posedge clk) begin
        if (!rst && !flush && wr_acc_c) begin
            for (int unsigned i = 0; i < ROWS; i++) begin
                amem_q[i][a_wp_q[i]] <= ainport[i*DW +: DW];
            end
            for (int unsigned j = 0; j < COLS; j++) begin
                wmem_q[j][w_wp_q[j]] <= winport[j*DW +: DW];
            end
        end
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            a_wp_q    <= '{default: '0};
            a_rp_q    <= '{default: '0};
            a_cnt_q   <= '{default: '0};
            w_wp_q    <= '{default: '0};
            w_rp_q    <= '{default: '0};
            w_cnt_q   <= '{default: '0};
            as_q      <= '0;
            ws_q      <= '0;
            avalid_q  <= '0;
            wvalid_q  <= '0;
            dly_q     <= '0;
            err_ovf_q <= 1'b0;
            err_udf_q <= 1'b0;
        end else begin
            a_wp_q    <= a_wp_d;
            a_rp_q    <= a_rp_d;
            a_cnt_q   <= a_cnt_d;
            w_wp_q    <= w_wp_d;
            w_rp_q    <= w_rp_d;
            w_cnt_q   <= w_cnt_d;
            as_q      <= as_d;
            ws_q      <= ws_d;
            avalid_q  <= avalid_d;
            wvalid_q  <= wvalid_d;
            dly_q     <= dly_d;
            err_ovf_q <= err_ovf_d;
            err_udf_q <= err_udf_d;
        end
    end

    assign as      = as_q;
    assign ws      = ws_q;
    assign avalid  = avalid_q;
    assign wvalid  = wvalid_q;
    // Any pending pop for channels 1.. means the wave is still in flight
    assign busy    = (MAXRC > 1) ? (|dly_q) : 1'b0;
    assign err_ovf = err_ovf_q;
    assign err_udf = err_udf_q;

endmodule

// File: tb/tb_skewed_input_ctrl.sv
// Self-checking bench for skewed_input_ctrl with a queue-based reference model.
module tb_skewed_input_ctrl;

    localparam int unsigned ROWS  = 8;
    localparam int unsigned COLS  = 8;
    localparam int unsigned DW    = 8;
    localparam int unsigned DEPTH = 16;
    localparam int unsigned MAXRC = (ROWS > COLS) ? ROWS : COLS;
    localparam int unsigned OW    = ROWS*DW + COLS*DW + 3*ROWS + 3*COLS + 3;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                 rst, flush, write, read;
    logic [ROWS*DW-1:0]   ainport;
    logic [COLS*DW-1:0]   winport;
    logic [ROWS-1:0]      afulls, aemptys, avalid;
    logic [COLS-1:0]      wfulls, wemptys, wvalid;
    logic [ROWS*DW-1:0]   as;
    logic [COLS*DW-1:0]   ws;
    logic                 busy, err_ovf, err_udf;

    skewed_input_ctrl #(.ROWS(ROWS), .COLS(COLS), .DW(DW), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .ainport(ainport), .winport(winport), .write(write), .read(read),
        .afulls(afulls), .wfulls(wfulls), .aemptys(aemptys), .wemptys(wemptys),
        .as(as), .ws(ws), .avalid(avalid), .wvalid(wvalid),
        .busy(busy), .err_ovf(err_ovf), .err_udf(err_udf)
    );

    int tests_run    = 0;
    int tests_failed = 0;

    // Reference model: one queue per channel, plus the set of edges at which read was taken.
    logic [DW-1:0]      aq [ROWS][$];
    logic [DW-1:0]      wq [COLS][$];
    bit                 read_at [int];
    int                 cyc = 0;
    logic [ROWS*DW-1:0] m_as;
    logic [COLS*DW-1:0] m_ws;
    logic [ROWS-1:0]    m_av;
    logic [COLS-1:0]    m_wv;
    logic               m_ovf = 1'b0;
    logic               m_udf = 1'b0;

    task automatic model_edge();
        bit full;
        bit acc;
        if (rst || flush) begin
            for (int i = 0; i < ROWS; i++) aq[i].delete();
            for (int j = 0; j < COLS; j++) wq[j].delete();
            read_at.delete();
            m_as = '0; m_ws = '0; m_av = '0; m_wv = '0;
            m_ovf = 1'b0; m_udf = 1'b0;
        end else begin
            full = 1'b0;
            for (int i = 0; i < ROWS; i++) if (aq[i].size() == DEPTH) full = 1'b1;
            for (int j = 0; j < COLS; j++) if (wq[j].size() == DEPTH) full = 1'b1;
            acc = write && !full;
            if (write && !acc) m_ovf = 1'b1;
            if (read) read_at[cyc] = 1'b1;
            m_as = '0; m_ws = '0; m_av = '0; m_wv = '0;
            for (int i = 0; i < ROWS; i++) begin
                if (read_at.exists(cyc - i)) begin
                    if (aq[i].size() > 0) begin
                        m_as[i*DW +: DW] = aq[i].pop_front();
                        m_av[i] = 1'b1;
                    end else m_udf = 1'b1;
                end
            end
            for (int j = 0; j < COLS; j++) begin
                if (read_at.exists(cyc - j)) begin
                    if (wq[j].size() > 0) begin
                        m_ws[j*DW +: DW] = wq[j].pop_front();
                        m_wv[j] = 1'b1;
                    end else m_udf = 1'b1;
                end
            end
            if (acc) begin
                for (int i = 0; i < ROWS; i++) aq[i].push_back(ainport[i*DW +: DW]);
                for (int j = 0; j < COLS; j++) wq[j].push_back(winport[j*DW +: DW]);
            end
        end
        cyc++;
    endtask

    // A wave is in flight while some channel beyond 0 still has a pop to come.
    function automatic logic m_busy();
        for (int k = 1; k < MAXRC; k++) if (read_at.exists(cyc - k)) return 1'b1;
        return 1'b0;
    endfunction

    function automatic logic [OW-1:0] exp_vec();
        logic [ROWS-1:0] af, ae;
        logic [COLS-1:0] wf, we;
        for (int i = 0; i < ROWS; i++) begin
            af[i] = (aq[i].size() == DEPTH);
            ae[i] = (aq[i].size() == 0);
        end
        for (int j = 0; j < COLS; j++) begin
            wf[j] = (wq[j].size() == DEPTH);
            we[j] = (wq[j].size() == 0);
        end
        return {m_as, m_ws, m_av, m_wv, af, wf, ae, we, m_busy(), m_ovf, m_udf};
    endfunction

    function automatic logic [OW-1:0] obs_vec();
        return {as, ws, avalid, wvalid, afulls, wfulls, aemptys, wemptys, busy, err_ovf, err_udf};
    endfunction

    function automatic logic [ROWS*DW-1:0] rnd_a();
        logic [ROWS*DW-1:0] v;
        for (int i = 0; i < ROWS; i++) v[i*DW +: DW] = DW'($urandom);
        return v;
    endfunction

    function automatic logic [COLS*DW-1:0] rnd_w();
        logic [COLS*DW-1:0] v;
        for (int j = 0; j < COLS; j++) v[j*DW +: DW] = DW'($urandom);
        return v;
    endfunction

    // Clock edge: advance the model with the inputs sampled at that edge, then settle.
    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic drive(input logic w, input logic r);
        write   = w;
        read    = r;
        ainport = rnd_a();
        winport = rnd_w();
    endtask

    task automatic do_flush();
        flush = 1'b1; write = 1'b0; read = 1'b0;
        tick();
        flush = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; flush = 1'b0;
        for (int c = 0; c < 2; c++) begin
            drive(1'b1, 1'b1);
            tick();
            tests_run++;
            if (obs_vec() !== exp_vec()) begin
                tests_failed++;
                $display("FAIL reset cyc=%0d got=%h exp=%h", cyc, obs_vec(), exp_vec());
            end
        end
        tests_run++;
        if ({aemptys, wemptys, afulls, wfulls, busy} !== {{(ROWS+COLS){1'b1}}, {(ROWS+COLS){1'b0}}, 1'b0}) begin
            tests_failed++;
            $display("FAIL reset_flags got=%h exp_empties_all_ones", {aemptys, wemptys, afulls, wfulls, busy});
        end
        rst = 1'b0;
        drive(1'b0, 1'b0);
    endtask

    task automatic test_skew();
        int busy_cycles;
        int first_v [ROWS];
        busy_cycles = 0;
        for (int i = 0; i < ROWS; i++) first_v[i] = -1;
        do_flush();
        write = 1'b1; read = 1'b0;
        for (int i = 0; i < ROWS; i++) ainport[i*DW +: DW] = DW'(i + 1);
        for (int j = 0; j < COLS; j++) winport[j*DW +: DW] = DW'(2*j + 1);
        tick();
        write = 1'b0; read = 1'b1;
        for (int c = 0; c < MAXRC + 4; c++) begin
            tick();
            read = 1'b0;
            if (busy === 1'b1) busy_cycles++;
            for (int i = 0; i < ROWS; i++) if (avalid[i] === 1'b1 && first_v[i] < 0) first_v[i] = c;
            tests_run++;
            if (obs_vec() !== exp_vec()) begin
                tests_failed++;
                $display("FAIL skew cyc=%0d got=%h exp=%h", cyc, obs_vec(), exp_vec());
            end
        end
        tests_run++;
        if (busy_cycles != MAXRC - 1) begin
            tests_failed++;
            $display("FAIL skew_busy_len got=%0d exp=%0d", busy_cycles, MAXRC - 1);
        end
        for (int i = 0; i < ROWS; i++) begin
            tests_run++;
            if (first_v[i] != i) begin
                tests_failed++;
                $display("FAIL skew_offset row=%0d got=%0d exp=%0d", i, first_v[i], i);
            end
        end
    endtask

    task automatic test_stream();
        do_flush();
        for (int k = 0; k < 16; k++) begin
            write = 1'b1; read = 1'b1;
            for (int i = 0; i < ROWS; i++) ainport[i*DW +: DW] = DW'(k + 16*i);
            for (int j = 0; j < COLS; j++) winport[j*DW +: DW] = DW'(k + 16*j + 128);
            tick();
            tests_run++;
            if (obs_vec() !== exp_vec()) begin
                tests_failed++;
                $display("FAIL stream cyc=%0d got=%h exp=%h", cyc, obs_vec(), exp_vec());
            end
        end
        drive(1'b0, 1'b0);
        for (int c = 0; c < MAXRC + 2; c++) begin
            tick();
            tests_run++;
            if (obs_vec() !== exp_vec()) begin
                tests_failed++;
                $display("FAIL stream_tail cyc=%0d got=%h exp=%h", cyc, obs_vec(), exp_vec());
            end
        end
        tests_run++;
        if ({err_udf, err_ovf} !== 2'b10) begin
            tests_failed++;
            $display("FAIL stream_err got=%b exp=10", {err_udf, err_ovf});
        end
    endtask

    task automatic test_fill();
        do_flush();
        // Advance pointers so the fill wraps around the storage
        for (int c = 0; c < 3; c++) begin drive(1'b1, 1'b0); tick(); end
        for (int c = 0; c < 3 + MAXRC; c++) begin drive(1'b0, c < 3); tick(); end
        for (int c = 0; c < DEPTH + 1; c++) begin
            drive(1'b1, 1'b0);
            tick();
            tests_run++;
            if (obs_vec() !== exp_vec()) begin
                tests_failed++;
                $display("FAIL fill cyc=%0d got=%h exp=%h", cyc, obs_vec(), exp_vec());
            end
        end
        tests_run++;
        if ({afulls, wfulls, err_ovf} !== {(ROWS+COLS+1){1'b1}}) begin
            tests_failed++;
            $display("FAIL fill_full got=%h exp=all_ones", {afulls, wfulls, err_ovf});
        end
        for (int c = 0; c < DEPTH + MAXRC; c++) begin
            drive(1'b0, c < DEPTH);
            tick();
            tests_run++;
            if (obs_vec() !== exp_vec()) begin
                tests_failed++;
                $display("FAIL fill_drain cyc=%0d got=%h exp=%h", cyc, obs_vec(), exp_vec());
            end
        end
    endtask

    task automatic test_full_pop();
        do_flush();
        for (int c = 0; c < DEPTH; c++) begin drive(1'b1, 1'b0); tick(); end
        drive(1'b1, 1'b1);
        tick();
        tests_run++;
        if (obs_vec() !== exp_vec()) begin
            tests_failed++;
            $display("FAIL full_pop cyc=%0d got=%h exp=%h", cyc, obs_vec(), exp_vec());
        end
        tests_run++;
        if ({err_ovf, afulls[0], afulls[1], avalid[0]} !== 4'b1011) begin
            tests_failed++;
            $display("FAIL full_pop_flags got=%b exp=1011", {err_ovf, afulls[0], afulls[1], avalid[0]});
        end
        drive(1'b0, 1'b0);
        for (int c = 0; c < MAXRC; c++) begin
            tick();
            tests_run++;
            if (obs_vec() !== exp_vec()) begin
                tests_failed++;
                $display("FAIL full_pop_tail cyc=%0d got=%h exp=%h", cyc, obs_vec(), exp_vec());
            end
        end
    endtask

    task automatic test_flush_midwave();
        do_flush();
        for (int c = 0; c < 4; c++) begin drive(1'b1, 1'b0); tick(); end
        drive(1'b0, 1'b1); tick();
        drive(1'b0, 1'b0); tick(); tick();
        flush = 1'b1;
        drive(1'b1, 1'b1);
        tick();
        flush = 1'b0;
        tests_run++;
        if ({aemptys, wemptys, busy, err_ovf, err_udf, avalid, wvalid, as, ws} !==
            {{(ROWS+COLS){1'b1}}, 3'b000, {(ROWS+COLS){1'b0}}, {((ROWS+COLS)*DW){1'b0}}}) begin
            tests_failed++;
            $display("FAIL flush_clear got=%h exp=empties_only", {aemptys, wemptys, busy, err_ovf, err_udf, avalid, wvalid});
        end
        drive(1'b0, 1'b0);
        for (int c = 0; c < MAXRC; c++) begin
            tick();
            tests_run++;
            if (obs_vec() !== exp_vec()) begin
                tests_failed++;
                $display("FAIL flush_after cyc=%0d got=%h exp=%h", cyc, obs_vec(), exp_vec());
            end
        end
    endtask

    task automatic test_random();
        do_flush();
        for (int c = 0; c < 600; c++) begin
            drive(($urandom % 100) < 55, ($urandom % 100) < 45);
            flush = (($urandom % 100) < 2);
            rst   = (($urandom % 200) < 1);
            tick();
            tests_run++;
            if (obs_vec() !== exp_vec()) begin
                tests_failed++;
                $display("FAIL random cyc=%0d got=%h exp=%h", cyc, obs_vec(), exp_vec());
            end
        end
        rst = 1'b0; flush = 1'b0;
    endtask

    initial begin
        rst = 1'b1; flush = 1'b0; write = 1'b0; read = 1'b0;
        ainport = '0; winport = '0;
        m_as = '0; m_ws = '0; m_av = '0; m_wv = '0;
        test_reset();
        test_skew();
        test_stream();
        test_fill();
        test_full_pop();
        test_flush_midwave();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
